dual_rail_tx: RTL and testbench

- Clocked initiator of the 4-phase return-to-zero dual-rail handshake that the asynchronous datapath blocks consume (data rails in, single ack back).
- Takes parallel words from a synchronous valid/ready source, buffers them in a small FIFO and launches each word as a dual-rail codeword, then a spacer, paced by the receiver's ack.
- Used to feed the async memory and instruction path from clocked test/loader logic, and as the sync-to-async bridge for the memory data-in port.

---
 rtl/dual_rail_tx_if.sv | 29 ++
 rtl/dual_rail_tx.sv | 155 +++++++++++++++
 tb/tb_dual_rail_tx.sv | 372 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dual_rail_tx_if.sv
// Bundle between the clocked word source / dual-rail receiver and the transmitter.
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready are both high;
// in_data must be held stable while in_valid is high and in_ready is low.
interface dual_rail_tx_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0]   in_data;
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] dr_out;
    logic               ack_in;

    // master: the word source together with the dual-rail receiver; slave: the transmitter
    modport master (
        output in_data,
        output in_valid,
        output ack_in,
        input  in_ready,
        input  dr_out
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  ack_in,
        output in_ready,
        output dr_out
    );
endinterface

// File: rtl/dual_rail_tx.sv
// Clocked initiator of a 4-phase return-to-zero dual-rail handshake: FIFO-buffered words are
// launched as registered codewords followed by spacers, paced by a synchronized ack.
module dual_rail_tx #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    dual_rail_tx_if.slave          bus,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] count,
    output logic                   timeout_err,
    input  logic                   err_clr,
    output logic [1:0]             state_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT);
    localparam logic [AW:0]   FULL     = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_NULL = 2'd2
    } state_e;

    state_e             state_q;
    logic [2*WIDTH-1:0] dr_q;
    logic [CW-1:0]      wait_q;
    logic               err_q;
    logic               ack_meta_q;
    logic               ack_s_q;
    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;
    logic [AW:0]        count_d;
    logic               push;
    logic               pop;
    logic               waiting;
    logic               timeout_hit;

    function automatic logic [2*WIDTH-1:0] encode(input logic [WIDTH-1:0] w);
        logic [2*WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i +: 2] = w[i] ? 2'b10 : 2'b01;
        end
        return r;
    endfunction

    // ack_in is asynchronous to clk; only the second flop feeds decisions
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_meta_q <= 1'b0;
            ack_s_q    <= 1'b0;
        end else begin
            ack_meta_q <= bus.ack_in;
            ack_s_q    <= ack_meta_q;
        end
    end

    assign bus.in_ready = (count_q < FULL);
    assign push         = bus.in_valid && bus.in_ready;
    assign pop          = (state_q == S_IDLE) && (count_q != '0) && !ack_s_q;

    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
        end
    end

    // A phase is "waiting" while ack_s has not yet reached the level that ends it
    assign waiting     = ((state_q == S_DATA) && !ack_s_q) || ((state_q == S_NULL) && ack_s_q);
    assign timeout_hit = waiting && (wait_q == WAIT_MAX - 1'b1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            dr_q    <= '0;
            wait_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        dr_q    <= encode(mem_q[rd_ptr_q]);
                        wait_q  <= '0;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (ack_s_q) begin
                        dr_q    <= '0;
                        wait_q  <= '0;
                        state_q <= S_NULL;
                    end else if (wait_q != WAIT_MAX) begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                S_NULL: begin
                    if (!ack_s_q) begin
                        state_q <= S_IDLE;
                    end else if (wait_q != WAIT_MAX) begin
                        wait_q <= wait_q + 1'b1;
                    end
                end
                default: begin
                    dr_q    <= '0;
                    state_q <= S_IDLE;
                end
            endcase

            // The protocol has no cancel, so a timeout only raises the flag
            if (timeout_hit) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign bus.dr_out  = dr_q;
    assign busy        = (state_q != S_IDLE);
    assign count       = count_q;
    assign timeout_err = err_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_dual_rail_tx.sv
// Self-checking bench for dual_rail_tx: directed scenarios plus a randomized producer/receiver
// run, all compared against a queue-based reference of what the receiver should see.
module tb_dual_rail_tx;
    localparam int W  = 16;
    localparam int D  = 4;
    localparam int TO = 8;
    localparam int BOUND = 20;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           err_clr = 1'b0;
    logic           busy;
    logic           timeout_err;
    logic [$clog2(D):0] count;
    logic [1:0]     state_o;

    int vectors = 0;
    int miscompares = 0;
    logic [W-1:0] exp_q[$];

    dual_rail_tx_if #(.WIDTH(W)) bus();

    dual_rail_tx #(.WIDTH(W), .DEPTH(D), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .busy(busy),
        .count(count),
        .timeout_err(timeout_err),
        .err_clr(err_clr),
        .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Each data bit i contributes 1 (logic 0) or 2 (logic 1) in base-4 digit i
    function automatic logic [2*W-1:0] ref_code(input logic [W-1:0] w);
        longint unsigned acc;
        acc = 0;
        for (int i = 0; i < W; i++) begin
            acc += (w[i] ? 64'd2 : 64'd1) << (2 * i);
        end
        return (2*W)'(acc);
    endfunction

    function automatic bit has_illegal(input logic [2*W-1:0] v);
        for (int i = 0; i < W; i++) begin
            if (v[2*i +: 2] == 2'b11) return 1'b1;
        end
        return 1'b0;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            vectors++;
            if (has_illegal(bus.dr_out)) begin
                miscompares++;
                $display("FAIL illegal_pair: dr_out=%h, required no 2'b11 pair", bus.dr_out);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_launch(output bit ok);
        int n = 0;
        while (bus.dr_out == '0 && n < BOUND) begin @(negedge clk); n++; end
        ok = (bus.dr_out != '0);
    endtask

    task automatic wait_spacer(output bit ok);
        int n = 0;
        while (bus.dr_out != '0 && n < BOUND) begin @(negedge clk); n++; end
        ok = (bus.dr_out == '0);
    endtask

    task automatic wait_idle(output bit ok);
        int n = 0;
        while (busy && n < BOUND) begin @(negedge clk); n++; end
        ok = !busy;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.ack_in = 1'b0;
        repeat (3) @(negedge clk);
        vectors++; if (bus.dr_out !== '0) begin miscompares++; $display("FAIL reset_dr_out: got %h want 0", bus.dr_out); end
        vectors++; if (count !== '0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", count); end
        vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b want 0", timeout_err); end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_single_word();
        bit ok;
        bus.in_data = 16'hA5C3;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++; if (count !== 1) begin miscompares++; $display("FAIL single_count_after_push: got %0d want 1", count); end
        vectors++; if (bus.dr_out !== '0) begin miscompares++; $display("FAIL single_not_early: got %h want 0", bus.dr_out); end
        @(negedge clk);
        vectors++; if (bus.dr_out !== 32'h9966A55A) begin miscompares++; $display("FAIL single_codeword: got %h want 9966a55a", bus.dr_out); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy: got %b want 1", busy); end
        vectors++; if (count !== 0) begin miscompares++; $display("FAIL single_count_after_pop: got %0d want 0", count); end
        repeat (2) @(negedge clk);
        bus.ack_in = 1'b1;
        repeat (2) @(negedge clk);
        vectors++; if (bus.dr_out !== 32'h9966A55A) begin miscompares++; $display("FAIL single_hold_until_sync: got %h want 9966a55a", bus.dr_out); end
        @(negedge clk);
        vectors++; if (bus.dr_out !== '0) begin miscompares++; $display("FAIL single_spacer: got %h want 0", bus.dr_out); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_null: got %b want 1", busy); end
        repeat (2) @(negedge clk);
        bus.ack_in = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL single_null_hold: got busy %b want 1", busy); end
        @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL single_idle: got busy %b want 0", busy); end
        ok = 1'b1;
    endtask

    task automatic test_encoding();
        logic [W-1:0] words [5];
        logic [2*W-1:0] want [5];
        bit ok;
        words[0] = 16'h0000; want[0] = 32'h55555555;
        words[1] = 16'hFFFF; want[1] = 32'hAAAAAAAA;
        words[2] = 16'h8001; want[2] = 32'h95555556;
        words[3] = W'($urandom); want[3] = ref_code(words[3]);
        words[4] = W'($urandom); want[4] = ref_code(words[4]);
        for (int k = 0; k < 5; k++) begin
            bus.in_data = words[k];
            bus.in_valid = 1'b1;
            @(negedge clk);
            bus.in_valid = 1'b0;
            @(negedge clk);
            vectors++; if (bus.dr_out !== want[k]) begin miscompares++; $display("FAIL encode_%0d: data %h got %h want %h", k, words[k], bus.dr_out, want[k]); end
            bus.ack_in = 1'b1;
            wait_spacer(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL encode_spacer_%0d: got %h want 0", k, bus.dr_out); end
            bus.ack_in = 1'b0;
            wait_idle(ok);
            vectors++; if (!ok) begin miscompares++; $display("FAIL encode_idle_%0d: got busy %b want 0", k, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w [3];
        bit ok;
        for (int k = 0; k < 3; k++) w[k] = W'($urandom);
        bus.in_data = w[0]; bus.in_valid = 1'b1; exp_q.push_back(w[0]);
        @(negedge clk);
        vectors++; if (count !== 1) begin miscompares++; $display("FAIL b2b_count_first: got %0d want 1", count); end
        bus.in_data = w[1]; exp_q.push_back(w[1]);
        @(negedge clk);
        vectors++; if (count !== 1) begin miscompares++; $display("FAIL b2b_push_pop_count: got %0d want 1", count); end
        vectors++; if (bus.dr_out !== ref_code(exp_q[0])) begin miscompares++; $display("FAIL b2b_first_word: got %h want %h", bus.dr_out, ref_code(exp_q[0])); end
        void'(exp_q.pop_front());
        bus.in_data = w[2]; exp_q.push_back(w[2]);
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++; if (count !== 2) begin miscompares++; $display("FAIL b2b_count_third: got %0d want 2", count); end
        for (int k = 1; k < 3; k++) begin
            bus.ack_in = 1'b1;
            wait_spacer(ok);
            bus.ack_in = 1'b0;
            wait_launch(ok);
            vectors++; if (!ok || bus.dr_out !== ref_code(exp_q[0])) begin miscompares++; $display("FAIL b2b_order_%0d: got %h want %h", k, bus.dr_out, ref_code(exp_q[0])); end
            void'(exp_q.pop_front());
        end
        bus.ack_in = 1'b1;
        wait_spacer(ok);
        bus.ack_in = 1'b0;
        wait_idle(ok);
        vectors++; if (!ok || count !== 0) begin miscompares++; $display("FAIL b2b_drained: got busy %b count %0d want 0 0", busy, count); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bus.ack_in = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            bus.in_data = W'(k);
            bus.in_valid = 1'b1;
            exp_q.push_back(W'(k));
            @(negedge clk);
            if (k == 2) begin
                vectors++; if (bus.dr_out !== ref_code(16'd1)) begin miscompares++; $display("FAIL bp_first_launch: got %h want %h", bus.dr_out, ref_code(16'd1)); end
            end
            if (k == 4) begin
                vectors++; if (count !== 3) begin miscompares++; $display("FAIL bp_count_three: got %0d want 3", count); end
            end
        end
        vectors++; if (count !== 4) begin miscompares++; $display("FAIL bp_count_full: got %0d want 4", count); end
        vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready); end
        bus.in_data = 16'd6;
        repeat (3) @(negedge clk);
        vectors++; if (count !== 4 || bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_sixth_held: got count %0d ready %b want 4 0", count, bus.in_ready); end
        bus.in_valid = 1'b0;
        void'(exp_q.pop_front());
        for (int k = 2; k <= 5; k++) begin
            bus.ack_in = 1'b1;
            wait_spacer(ok);
            bus.ack_in = 1'b0;
            wait_launch(ok);
            vectors++; if (!ok || bus.dr_out !== ref_code(exp_q[0])) begin miscompares++; $display("FAIL bp_drain_%0d: got %h want %h", k, bus.dr_out, ref_code(exp_q[0])); end
            void'(exp_q.pop_front());
        end
        bus.ack_in = 1'b1;
        wait_spacer(ok);
        bus.ack_in = 1'b0;
        wait_idle(ok);
        vectors++; if (!ok || count !== 0) begin miscompares++; $display("FAIL bp_drained: got busy %b count %0d want 0 0", busy, count); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL bp_err_clr: got %b want 0", timeout_err); end
    endtask

    task automatic test_timeout();
        logic [W-1:0] w;
        bit ok;
        w = W'($urandom);
        bus.in_data = w; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        repeat (TO - 1) @(negedge clk);
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_not_early: got %b want 0", timeout_err); end
        @(negedge clk);
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_set: got %b want 1", timeout_err); end
        vectors++; if (bus.dr_out !== ref_code(w)) begin miscompares++; $display("FAIL to_hold_codeword: got %h want %h", bus.dr_out, ref_code(w)); end
        repeat (4) @(negedge clk);
        vectors++; if (timeout_err !== 1'b1 || busy !== 1'b1) begin miscompares++; $display("FAIL to_sticky_wait: got err %b busy %b want 1 1", timeout_err, busy); end
        bus.ack_in = 1'b1;
        wait_spacer(ok);
        bus.ack_in = 1'b0;
        wait_idle(ok);
        vectors++; if (!ok || timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_complete: got busy %b err %b want 0 1", busy, timeout_err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clear: got %b want 0", timeout_err); end
        w = W'($urandom);
        bus.in_data = w; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        repeat (TO - 2) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL to_clr_before: got %b want 0", timeout_err); end
        @(negedge clk);
        err_clr = 1'b0;
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL to_set_wins: got %b want 1", timeout_err); end
        bus.ack_in = 1'b1;
        wait_spacer(ok);
        bus.ack_in = 1'b0;
        wait_idle(ok);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
    endtask

    task automatic test_random();
        localparam int N = 24;
        fork
            begin
                logic [W-1:0] w;
                int n;
                for (int k = 0; k < N; k++) begin
                    w = W'($urandom);
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    bus.in_data = w;
                    bus.in_valid = 1'b1;
                    n = 0;
                    while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
                    vectors++; if (!bus.in_ready) begin miscompares++; $display("FAIL rnd_accept_%0d: got in_ready 0 want 1", k); end
                    exp_q.push_back(w);
                    @(negedge clk);
                    bus.in_valid = 1'b0;
                end
            end
            begin
                bit ok;
                logic [2*W-1:0] want;
                for (int k = 0; k < N; k++) begin
                    wait_launch(ok);
                    want = (exp_q.size() != 0) ? ref_code(exp_q.pop_front()) : '0;
                    vectors++; if (!ok || bus.dr_out !== want) begin miscompares++; $display("FAIL rnd_word_%0d: got %h want %h", k, bus.dr_out, want); end
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    bus.ack_in = 1'b1;
                    wait_spacer(ok);
                    vectors++; if (!ok || busy !== 1'b1) begin miscompares++; $display("FAIL rnd_spacer_%0d: got %h busy %b want 0 1", k, bus.dr_out, busy); end
                    repeat ($urandom_range(0, 4)) @(negedge clk);
                    bus.ack_in = 1'b0;
                end
            end
        join
        begin
            bit ok;
            wait_idle(ok);
            vectors++; if (!ok || count !== 0 || exp_q.size() != 0) begin miscompares++; $display("FAIL rnd_drained: got busy %b count %0d left %0d want 0 0 0", busy, count, exp_q.size()); end
            vectors++; if (timeout_err !== 1'b0) begin miscompares++; $display("FAIL rnd_no_timeout: got %b want 0", timeout_err); end
        end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] w;
        bit ok;
        bus.ack_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = W'($urandom);
            bus.in_valid = 1'b1;
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        vectors++; if (count !== 2 || busy !== 1'b1) begin miscompares++; $display("FAIL rm_setup: got count %0d busy %b want 2 1", count, busy); end
        repeat (TO) @(negedge clk);
        vectors++; if (timeout_err !== 1'b1) begin miscompares++; $display("FAIL rm_err_before: got %b want 1", timeout_err); end
        bus.ack_in = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        vectors++; if (bus.dr_out !== '0) begin miscompares++; $display("FAIL rm_dr_out: got %h want 0", bus.dr_out); end
        vectors++; if (count !== 0 || bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rm_fifo: got count %0d ready %b want 0 1", count, bus.in_ready); end
        vectors++; if (busy !== 1'b0 || timeout_err !== 1'b0) begin miscompares++; $display("FAIL rm_state: got busy %b err %b want 0 0", busy, timeout_err); end
        repeat (3) @(negedge clk);
        w = W'($urandom);
        bus.in_data = w; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (4) @(negedge clk);
        vectors++; if (bus.dr_out !== '0 || busy !== 1'b0 || count !== 1) begin miscompares++; $display("FAIL rm_no_launch_ack_high: got %h busy %b count %0d want 0 0 1", bus.dr_out, busy, count); end
        bus.ack_in = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (bus.dr_out !== '0) begin miscompares++; $display("FAIL rm_wait_sync: got %h want 0", bus.dr_out); end
        @(negedge clk);
        vectors++; if (bus.dr_out !== ref_code(w)) begin miscompares++; $display("FAIL rm_launch: got %h want %h", bus.dr_out, ref_code(w)); end
        bus.ack_in = 1'b1;
        wait_spacer(ok);
        bus.ack_in = 1'b0;
        wait_idle(ok);
        vectors++; if (!ok || count !== 0) begin miscompares++; $display("FAIL rm_drained: got busy %b count %0d want 0 0", busy, count); end
    endtask

    initial begin
        bus.in_data = '0;
        bus.in_valid = 1'b0;
        bus.ack_in = 1'b0;
        test_reset();
        test_single_word();
        test_encoding();
        test_back_to_back();
        test_backpressure();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
